float_copro_issue: RTL

Issue/return stage directly upstream of the float coprocessor. It buffers CPU-side float requests in a small FIFO and drives them one at a time through the coprocessor's valid/complete/accept handshake. It captures each result into a single-entry result register with a valid/ready interface back to the CPU. It also rejects illegal opcodes, runs a watchdog against hung operations, and flushes the coprocessor after reset.

---
 rtl/float_copro_issue_if.sv | 38 +++
 rtl/float_copro_issue.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/float_copro_issue_if.sv
// Bundle of the CPU request/result handshakes and the coprocessor handshake
// around the float coprocessor issue stage.
interface float_copro_issue_if #(
    parameter int DEPTH = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic [10:0]             req_opcode;
    logic [31:0]             req_op0;
    logic [31:0]             req_op1;
    logic                    res_valid;
    logic                    res_ready;
    logic [31:0]             res_data;
    logic [1:0]              res_err;
    logic                    copro_valid;
    logic                    copro_accept;
    logic [10:0]             copro_opcode;
    logic [31:0]             copro_op0;
    logic [31:0]             copro_op1;
    logic                    copro_complete;
    logic [31:0]             copro_result;
    logic                    busy;
    logic [$clog2(DEPTH):0]  occupancy;

    modport master (
        output req_valid, req_opcode, req_op0, req_op1, res_ready,
               copro_complete, copro_result,
        input  req_ready, res_valid, res_data, res_err, copro_valid,
               copro_accept, copro_opcode, copro_op0, copro_op1, busy, occupancy
    );

    modport slave (
        input  req_valid, req_opcode, req_op0, req_op1, res_ready,
               copro_complete, copro_result,
        output req_ready, res_valid, res_data, res_err, copro_valid,
               copro_accept, copro_opcode, copro_op0, copro_op1, busy, occupancy
    );
endinterface

// File: rtl/float_copro_issue.sv
// Issue/return stage for the float coprocessor: request FIFO, single-op
// handshake FSM with watchdog, and a one-entry result register.
module float_copro_issue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    float_copro_issue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_FLUSH  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ACCEPT = 3'd4
    } state_t;

    logic [10:0]   fifo_opc_r [DEPTH];
    logic [31:0]   fifo_op0_r [DEPTH];
    logic [31:0]   fifo_op1_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    state_t        state_r;
    logic          copro_valid_r;
    logic          copro_accept_r;
    logic [10:0]   copro_opcode_r;
    logic [31:0]   copro_op0_r;
    logic [31:0]   copro_op1_r;
    logic [TW-1:0] timer_r;
    logic [31:0]   cap_data_r;
    logic [1:0]    cap_err_r;
    logic          res_valid_r;
    logic [31:0]   res_data_r;
    logic [1:0]    res_err_r;

    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic [10:0]   head_opc_s;

    assign full_s     = (count_r == CW'(DEPTH));
    assign empty_s    = (count_r == {CW{1'b0}});
    assign push_s     = bus.req_valid && !full_s;
    assign pop_s      = (state_r == ST_IDLE) && !empty_s && !res_valid_r;
    assign head_opc_s = fifo_opc_r[rd_ptr_r];

    // Request FIFO storage, pointers and entry count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_opc_r[wr_ptr_r] <= bus.req_opcode;
                fifo_op0_r[wr_ptr_r] <= bus.req_op0;
                fifo_op1_r[wr_ptr_r] <= bus.req_op1;
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Handshake FSM, watchdog, capture and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_FLUSH;
            copro_valid_r  <= 1'b0;
            copro_accept_r <= 1'b1;
            copro_opcode_r <= 11'd0;
            copro_op0_r    <= 32'd0;
            copro_op1_r    <= 32'd0;
            timer_r        <= {TW{1'b0}};
            cap_data_r     <= 32'd0;
            cap_err_r      <= 2'b00;
            res_valid_r    <= 1'b0;
            res_data_r     <= 32'd0;
            res_err_r      <= 2'b00;
        end else begin
            copro_valid_r  <= 1'b0;
            copro_accept_r <= 1'b0;
            if (res_valid_r && bus.res_ready) begin
                res_valid_r <= 1'b0;
            end
            case (state_r)
                ST_FLUSH: begin
                    state_r <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (pop_s) begin
                        copro_opcode_r <= head_opc_s;
                        copro_op0_r    <= fifo_op0_r[rd_ptr_r];
                        copro_op1_r    <= fifo_op1_r[rd_ptr_r];
                        if (head_opc_s > 11'd3) begin
                            // Illegal opcode is answered locally; coprocessor untouched.
                            res_data_r  <= 32'd0;
                            res_err_r   <= 2'b01;
                            res_valid_r <= 1'b1;
                        end else begin
                            state_r       <= ST_ISSUE;
                            copro_valid_r <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                    timer_r <= {TW{1'b0}};
                end
                ST_WAIT: begin
                    if (bus.copro_complete) begin
                        cap_data_r     <= bus.copro_result;
                        cap_err_r      <= 2'b00;
                        state_r        <= ST_ACCEPT;
                        copro_accept_r <= 1'b1;
                    end else if (timer_r == TIMER_MAX) begin
                        cap_data_r     <= 32'hFFC0_0000;
                        cap_err_r      <= 2'b10;
                        state_r        <= ST_ACCEPT;
                        copro_accept_r <= 1'b1;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_ACCEPT: begin
                    res_data_r  <= cap_data_r;
                    res_err_r   <= cap_err_r;
                    res_valid_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r        <= ST_FLUSH;
                    copro_accept_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready    = !full_s;
    assign bus.res_valid    = res_valid_r;
    assign bus.res_data     = res_data_r;
    assign bus.res_err      = res_err_r;
    assign bus.copro_valid  = copro_valid_r;
    assign bus.copro_accept = copro_accept_r;
    assign bus.copro_opcode = copro_opcode_r;
    assign bus.copro_op0    = copro_op0_r;
    assign bus.copro_op1    = copro_op1_r;
    assign bus.busy         = (state_r != ST_IDLE) || !empty_s;
    assign bus.occupancy    = count_r;
endmodule
